// File: rtl/retire_monitor_if.sv
// Commit-port bundle seen by the retirement monitor: per-lane retire strobes, PCs and exception code.
interface retire_monitor_if #(
   parameter int WAYS = 2,
   parameter int XLEN = 32
);
   logic [WAYS-1:0]      commit_valid;
   logic [WAYS*XLEN-1:0] commit_PC;
   logic [3:0]           error_status;

   modport master (output commit_valid, output commit_PC, output error_status);
   modport slave  (input  commit_valid, input  commit_PC, input  error_status);
endinterface

// File: rtl/retire_monitor.sv
// Retirement monitor: cycle/instr counters, fatal-code and watchdog halt, RUN->DRAIN->HALTED; optional PC ring under RETIRE_TRACE_EN.
// Outputs registered one edge after the sampled commit (trace_rd_pc is a combinational read); never backpressures the commit port.
module retire_monitor #(
   parameter int          WAYS         = 2,
   parameter int          XLEN         = 32,
   parameter int          CNT_W        = 64,
   parameter int          WDOG_W       = 32,
   parameter int          WDOG_LIMIT   = 50000,
   parameter int          DRAIN_CYCLES = 2,
   parameter logic [15:0] FATAL_MASK   = ~16'h0021,
   parameter int          TRACE_DEPTH  = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear,
   retire_monitor_if.slave                cm,
   output logic [CNT_W-1:0]               cycle_count,
   output logic [CNT_W-1:0]               instr_count,
   output logic [WDOG_W-1:0]              idle_cycles,
   output logic                           halted,
   output logic [1:0]                     halt_cause,
   output logic [3:0]                     halt_code,
   output logic [XLEN-1:0]                last_PC,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
   output logic [XLEN-1:0]                trace_rd_pc,
   output logic [$clog2(TRACE_DEPTH):0]   trace_fill
);
   localparam int NW = $clog2(WAYS + 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d, instr_q, instr_d;
   logic [WDOG_W-1:0] idle_q, idle_d, idle_next;
   logic              halted_q, halted_d;
   logic [1:0]        cause_q, cause_d;
   logic [3:0]        code_q, code_d;
   logic [XLEN-1:0]   last_pc_q, last_pc_d, youngest_pc;
   logic [7:0]        drain_q, drain_d;
   logic [NW-1:0]     n;
   logic [CNT_W:0]    cyc_sum, ins_sum;
   logic              active, fatal, wdog;

   always_comb begin
      n           = '0;
      youngest_pc = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (cm.commit_valid[i]) begin
            n           = n + NW'(1);
            youngest_pc = cm.commit_PC[i*XLEN +: XLEN];
         end
      end
   end

   assign active    = (state_q != ST_HALTED);
   assign fatal     = FATAL_MASK[cm.error_status];
   assign idle_next = (n != '0) ? '0 : ((&idle_q) ? idle_q : idle_q + WDOG_W'(1));
   assign wdog      = (WDOG_LIMIT != 0) && (idle_next == WDOG_W'(WDOG_LIMIT));
   assign cyc_sum   = {1'b0, cycle_q} + (CNT_W+1)'(1);
   assign ins_sum   = {1'b0, instr_q} + (CNT_W+1)'(n);

   always_comb begin
      state_d   = state_q;
      cycle_d   = cycle_q;
      instr_d   = instr_q;
      idle_d    = idle_q;
      halted_d  = halted_q;
      cause_d   = cause_q;
      code_d    = code_q;
      last_pc_d = last_pc_q;
      drain_d   = drain_q;
      if (clear) begin
         state_d   = ST_RUN;
         cycle_d   = '0;
         instr_d   = '0;
         idle_d    = '0;
         halted_d  = 1'b0;
         cause_d   = 2'd0;
         code_d    = 4'd0;
         last_pc_d = '0;
         drain_d   = '0;
      end else if (active) begin
         cycle_d = cyc_sum[CNT_W] ? '1 : cyc_sum[CNT_W-1:0];
         instr_d = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
         idle_d  = idle_next;
         if (n != '0) last_pc_d = youngest_pc;
         // The trigger cycle still counts; only RUN listens for new triggers.
         if (state_q == ST_RUN) begin
            if (fatal || wdog) begin
               cause_d = fatal ? 2'd1 : 2'd2;
               code_d  = cm.error_status;
               if (DRAIN_CYCLES == 0) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = 8'(DRAIN_CYCLES);
               end
            end
         end else if (drain_q <= 8'd1) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
            drain_d  = '0;
         end else begin
            drain_d = drain_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         cycle_q   <= '0;
         instr_q   <= '0;
         idle_q    <= '0;
         halted_q  <= 1'b0;
         cause_q   <= 2'd0;
         code_q    <= 4'd0;
         last_pc_q <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
         idle_q    <= idle_d;
         halted_q  <= halted_d;
         cause_q   <= cause_d;
         code_q    <= code_d;
         last_pc_q <= last_pc_d;
         drain_q   <= drain_d;
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
   assign idle_cycles = idle_q;
   assign halted      = halted_q;
   assign halt_cause  = cause_q;
   assign halt_code   = code_q;
   assign last_PC     = last_pc_q;

`ifdef RETIRE_TRACE_EN
   localparam int TW = $clog2(TRACE_DEPTH);

   logic [XLEN-1:0] ring_q [TRACE_DEPTH];
   logic [XLEN-1:0] ring_d [TRACE_DEPTH];
   logic [TW-1:0]   wr_ptr_q, wr_ptr_d, rd_slot;
   logic [TW:0]     fill_q, fill_d;
   logic [TW+NW:0]  fill_sum;

   assign fill_sum = {{NW{1'b0}}, fill_q} + {{(TW+1){1'b0}}, n};

   // Lanes written oldest first, so a burst wider than the ring leaves the youngest PCs.
   always_comb begin
      logic [TW-1:0] off;
      ring_d   = ring_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      off      = wr_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         fill_d   = '0;
      end else if (active) begin
         for (int i = 0; i < WAYS; i++) begin
            if (cm.commit_valid[i]) begin
               ring_d[off] = cm.commit_PC[i*XLEN +: XLEN];
               off         = off + TW'(1);
            end
         end
         wr_ptr_d = off;
         fill_d   = (fill_sum > (TW+NW+1)'(TRACE_DEPTH)) ? (TW+1)'(TRACE_DEPTH) : fill_sum[TW:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TRACE_DEPTH; i++) ring_q[i] <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         ring_q   <= ring_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign rd_slot     = wr_ptr_q - trace_rd_idx - TW'(1);
   assign trace_rd_pc = ({1'b0, trace_rd_idx} < fill_q) ? ring_q[rd_slot] : '0;
   assign trace_fill  = fill_q;
`else
   logic unused_trace_idx;
   assign unused_trace_idx = ^trace_rd_idx;
   assign trace_rd_pc      = '0;
   assign trace_fill       = '0;
`endif
endmodule

// File: tb/tb_retire_monitor.sv
// Randomized bench for retire_monitor against a cycle-level behavioural model; trace checks follow RETIRE_TRACE_EN.
module tb_retire_monitor;
   localparam int WAYS = 2, XLEN = 32, CNT_W = 8, WDOG_W = 32;
   localparam int WDOG_LIMIT = 8, DRAIN_CYCLES = 2, TRACE_DEPTH = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [3:0] NO_ERROR = 4'd0, ILLEGAL_INST = 4'd2, LOAD_ACCESS_FAULT = 4'd5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;
   logic [CNT_W-1:0]  cycle_count, instr_count;
   logic [WDOG_W-1:0] idle_cycles;
   logic              halted;
   logic [1:0]        halt_cause;
   logic [3:0]        halt_code;
   logic [XLEN-1:0]   last_PC, trace_rd_pc;
   logic [1:0]        trace_rd_idx;
   logic [2:0]        trace_fill;

   retire_monitor_if #(.WAYS(WAYS), .XLEN(XLEN)) cm ();

   retire_monitor #(
      .WAYS(WAYS), .XLEN(XLEN), .CNT_W(CNT_W), .WDOG_W(WDOG_W), .WDOG_LIMIT(WDOG_LIMIT),
      .DRAIN_CYCLES(DRAIN_CYCLES), .FATAL_MASK(~16'h0021), .TRACE_DEPTH(TRACE_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .clear(clear), .cm(cm),
      .cycle_count(cycle_count), .instr_count(instr_count), .idle_cycles(idle_cycles),
      .halted(halted), .halt_cause(halt_cause), .halt_code(halt_code), .last_PC(last_PC),
      .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_fill(trace_fill)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 = RUN, 1 = DRAIN, 2 = HALTED.
   int          m_cycles, m_instr, m_idle, m_mode, m_left, m_cause, m_code;
   logic [31:0] m_last_pc;
   logic [31:0] m_trace[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic model_reset();
      m_cycles = 0; m_instr = 0; m_idle = 0; m_mode = 0; m_left = 0;
      m_cause = 0; m_code = 0; m_last_pc = '0;
      m_trace.delete();
   endtask

   task automatic model_step();
      int   n;
      logic [31:0] pc;
      bit   fatal, wd;
      if (clear) begin
         model_reset();
         return;
      end
      if (m_mode == 2) return;
      n = 0;
      for (int i = 0; i < WAYS; i++) begin
         if (cm.commit_valid[i]) begin
            n++;
            pc = cm.commit_PC[i*XLEN +: XLEN];
            m_last_pc = pc;
            m_trace.push_front(pc);
            if (m_trace.size() > TRACE_DEPTH) void'(m_trace.pop_back());
         end
      end
      m_cycles = sat(m_cycles + 1);
      m_instr  = sat(m_instr + n);
      m_idle   = (n > 0) ? 0 : m_idle + 1;
      if (m_mode == 0) begin
         fatal = !(cm.error_status == NO_ERROR || cm.error_status == LOAD_ACCESS_FAULT);
         wd    = (WDOG_LIMIT != 0) && (m_idle == WDOG_LIMIT);
         if (fatal || wd) begin
            m_cause = fatal ? 1 : 2;
            m_code  = int'(cm.error_status);
            m_left  = DRAIN_CYCLES;
            m_mode  = (DRAIN_CYCLES == 0) ? 2 : 1;
         end
      end else begin
         m_left--;
         if (m_left == 0) m_mode = 2;
      end
   endtask

   function automatic logic [31:0] exp_trace_pc(input int idx);
`ifdef RETIRE_TRACE_EN
      return (idx < m_trace.size()) ? m_trace[idx] : 32'h0;
`else
      return 32'h0;
`endif
   endfunction

   function automatic int exp_fill();
`ifdef RETIRE_TRACE_EN
      return m_trace.size();
`else
      return 0;
`endif
   endfunction

   task automatic check_all();
      check_eq("cycle_count", cycle_count, m_cycles);
      check_eq("instr_count", instr_count, m_instr);
      check_eq("idle_cycles", idle_cycles, m_idle);
      check_eq("halted",      halted,      (m_mode == 2));
      check_eq("halt_cause",  halt_cause,  m_cause);
      check_eq("halt_code",   halt_code,   m_code);
      check_eq("last_PC",     last_PC,     m_last_pc);
      check_eq("trace_fill",  trace_fill,  exp_fill());
      check_eq("trace_rd_pc", trace_rd_pc, exp_trace_pc(int'(trace_rd_idx)));
   endtask

   task automatic tick(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [3:0] err, input logic clr);
      cm.commit_valid = v;
      cm.commit_PC    = {p1, p0};
      cm.error_status = err;
      clear           = clr;
      trace_rd_idx    = 2'($urandom_range(0, 3));
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   function automatic logic [31:0] rpc();
      return {$urandom_range(0, 32'h3fff_ffff), 2'b00};
   endfunction

   initial begin
      logic [3:0] err;
      logic [1:0] v;
      int         r;
      cm.commit_valid = '0;
      cm.commit_PC    = '0;
      cm.error_status = NO_ERROR;
      trace_rd_idx    = '0;
      model_reset();

      // Reset state, then idle RUN.
      #12;
      check_all();
      @(negedge clock) reset = 1'b1;
      repeat (3) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t1_idle", idle_cycles, 3);
      check_eq("t1_instr", instr_count, 0);

      // 10 dual retirements then 5 single.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      repeat (10) tick(2'b11, rpc(), rpc(), NO_ERROR, 1'b0);
      repeat (5)  tick(2'b01, rpc(), rpc(), NO_ERROR, 1'b0);
      check_eq("t2_instr", instr_count, 25);
      check_eq("t2_cycle", cycle_count, 15);
      check_eq("t2_idle",  idle_cycles, 0);

      // Fatal code on a retiring cycle, DRAIN of 2, then frozen.
      tick(2'b01, 32'h100, 0, ILLEGAL_INST, 1'b0);
      check_eq("t3_halt_e1", halted, 0);
      check_eq("t3_instr", instr_count, 26);
      tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t3_halt_e2", halted, 0);
      tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t3_halt_e3", halted, 1);
      check_eq("t3_cause", halt_cause, 1);
      check_eq("t3_code", halt_code, ILLEGAL_INST);
      repeat (4) tick(2'b11, rpc(), rpc(), NO_ERROR, 1'b0);
      check_eq("t3_frozen_cyc", cycle_count, 18);
      check_eq("t3_frozen_ins", instr_count, 26);
      check_eq("t3_frozen_pc", last_PC, 32'h100);

      // Non-fatal code, then watchdog, then a near-miss.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      repeat (20) tick(2'($urandom_range(1, 3)), rpc(), rpc(), LOAD_ACCESS_FAULT, 1'b0);
      check_eq("t4_no_halt", halted, 0);
      repeat (10) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t4_wdog_halt", halted, 1);
      check_eq("t4_wdog_cause", halt_cause, 2);
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      repeat (7) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      tick(2'b10, 0, 32'h44, NO_ERROR, 1'b0);
      repeat (7) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t4_near_miss", halt_cause, 0);
      check_eq("t4_idle7", idle_cycles, 7);

      // Fatal and watchdog together; async reset mid-DRAIN; clear out of HALTED.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      repeat (7) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      tick(2'b00, 0, 0, ILLEGAL_INST, 1'b0);
      check_eq("t5_both_cause", halt_cause, 1);
      #3 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clock) reset = 1'b1;
      tick(2'b01, 32'h200, 0, 4'd7, 1'b0);
      repeat (2) tick(2'b00, 0, 0, NO_ERROR, 1'b0);
      check_eq("t5_halted", halted, 1);
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      check_eq("t5_cleared", halted, 0);
      tick(2'b01, 32'h300, 0, NO_ERROR, 1'b0);
      check_eq("t5_running", cycle_count, 1);

      // Ring contents after five retirements.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      tick(2'b11, 32'h0, 32'h4, NO_ERROR, 1'b0);
      tick(2'b11, 32'h8, 32'hC, NO_ERROR, 1'b0);
      tick(2'b01, 32'h10, 0, NO_ERROR, 1'b0);
      trace_rd_idx = 2'd0;
      #1 check_eq("t6_idx0", trace_rd_pc, exp_trace_pc(0));
      trace_rd_idx = 2'd3;
      #1 check_eq("t6_idx3", trace_rd_pc, exp_trace_pc(3));
      check_eq("t6_fill", trace_fill, exp_fill());
`ifdef RETIRE_TRACE_EN
      check_eq("t6_idx3_abs", trace_rd_pc, 32'h4);
`else
      check_eq("t6_idx3_abs", trace_rd_pc, 32'h0);
`endif

      // Counter saturation.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      repeat (260) tick(2'b11, rpc(), rpc(), NO_ERROR, 1'b0);
      check_eq("sat_instr", instr_count, CNT_MAX);
      check_eq("sat_cycle", cycle_count, CNT_MAX);

      // Random traffic.
      tick(2'b00, 0, 0, NO_ERROR, 1'b1);
      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            err = 4'($urandom_range(1, 15));
            if (err == LOAD_ACCESS_FAULT) err = ILLEGAL_INST;
         end else if (r < 50) err = LOAD_ACCESS_FAULT;
         else err = NO_ERROR;
         v = ($urandom_range(0, 99) < 35) ? 2'b00 : 2'($urandom_range(0, 3));
         tick(v, rpc(), rpc(), err, ($urandom_range(0, 99) < 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
